// File: rtl/core_pkg.sv
// Shared core definitions: MEM-stage FSM encoding, default datapath width and
// the timeout counter width helper.
package core_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // Bits needed to count 0 .. cycles-1; at least one bit so the counter always exists.
    function automatic int unsigned timeout_ctr_width(input int unsigned cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Clear/enable cycle counter with a terminal flag at LIMIT-1; LIMIT=0 never fires.
// Shared by the data-memory handshake and future fetch-side handshakes.
module mem_timeout_ctr
    import core_pkg::*;
#(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned W = timeout_ctr_width(LIMIT);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + W'(1);
        end
    end

    generate
        if (LIMIT == 0) begin : g_never
            assign terminal = 1'b0;
        end else begin : g_limit
            assign terminal = (count_q == W'(LIMIT - 1));
        end
    endgenerate

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: data-memory request/ready handshake with timeout, feeding MEM/WB.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN           = XLEN_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] alu_result_EX_MEM,
    input  logic [XLEN-1:0] read_data2_EX_MEM,
    input  logic            memread_EX_MEM,
    input  logic            memwrite_EX_MEM,
    input  logic            memtoreg_EX_MEM,
    input  logic            regwrite_EX_MEM,
    input  logic [4:0]      rd_EX_MEM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            mem_stall,
    output logic [XLEN-1:0] alu_result_MEM_WB,
    output logic [XLEN-1:0] read_data_MEM_WB,
    output logic            memtoreg_MEM_WB,
    output logic            regwrite_MEM_WB,
    output logic [4:0]      rd_MEM_WB,
    output logic            bus_err_MEM_WB
);

    mem_state_e      state_q;
    logic            req_q, we_q, mtr_wb_q, rw_wb_q, berr_q;
    logic [XLEN-1:0] addr_q, wdata_q, alu_wb_q, rdata_wb_q;
    logic [4:0]      rd_wb_q;
    logic            mem_op, misalign, timeout_hit;

    assign mem_op = memread_EX_MEM | memwrite_EX_MEM;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = mem_op & (alu_result_EX_MEM[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    mem_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_q == MEM_IDLE),
        .enable   (state_q == MEM_WAIT),
        .terminal (timeout_hit)
    );

    assign mem_stall = ((state_q == MEM_IDLE) & mem_op & ~misalign) |
                       ((state_q == MEM_WAIT) & ~dmem_ready & ~timeout_hit);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= MEM_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            alu_wb_q   <= '0;
            rdata_wb_q <= '0;
            mtr_wb_q   <= 1'b0;
            rw_wb_q    <= 1'b0;
            rd_wb_q    <= '0;
            berr_q     <= 1'b0;
        end else begin
            berr_q <= 1'b0;
            case (state_q)
                MEM_IDLE: begin
                    if (misalign) begin
                        rw_wb_q <= 1'b0;
                        berr_q  <= 1'b1;
                    end else if (mem_op) begin
                        req_q   <= 1'b1;
                        we_q    <= memwrite_EX_MEM & ~memread_EX_MEM;
                        addr_q  <= alu_result_EX_MEM;
                        wdata_q <= read_data2_EX_MEM;
                        rw_wb_q <= 1'b0;  // bubble while the access is in flight
                        state_q <= MEM_WAIT;
                    end else begin
                        alu_wb_q <= alu_result_EX_MEM;
                        mtr_wb_q <= memtoreg_EX_MEM;
                        rw_wb_q  <= regwrite_EX_MEM;
                        rd_wb_q  <= rd_EX_MEM;
                    end
                end
                MEM_WAIT: begin
                    // Ready takes priority over a simultaneous timeout.
                    if (dmem_ready) begin
                        req_q    <= 1'b0;
                        alu_wb_q <= alu_result_EX_MEM;
                        mtr_wb_q <= memtoreg_EX_MEM;
                        rw_wb_q  <= regwrite_EX_MEM;
                        rd_wb_q  <= rd_EX_MEM;
                        if (memread_EX_MEM) begin
                            rdata_wb_q <= dmem_rdata;
                        end
                        state_q <= MEM_IDLE;
                    end else if (timeout_hit) begin
                        req_q   <= 1'b0;
                        rw_wb_q <= 1'b0;
                        berr_q  <= 1'b1;
                        state_q <= MEM_IDLE;
                    end
                end
                default: state_q <= MEM_IDLE;
            endcase
        end
    end

    assign dmem_req          = req_q;
    assign dmem_we           = we_q;
    assign dmem_addr         = addr_q;
    assign dmem_wdata        = wdata_q;
    assign alu_result_MEM_WB = alu_wb_q;
    assign read_data_MEM_WB  = rdata_wb_q;
    assign memtoreg_MEM_WB   = mtr_wb_q;
    assign regwrite_MEM_WB   = rw_wb_q;
    assign rd_MEM_WB         = rd_wb_q;
    assign bus_err_MEM_WB    = berr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected MEM/WB results and memory requests are
// queued at issue time and popped by independent monitors.
module tb_mem_wb_stage;

    localparam int unsigned XLEN = 32;
    localparam int unsigned TO   = 4;

    logic            clk, reset;
    logic [XLEN-1:0] alu_result_EX_MEM, read_data2_EX_MEM;
    logic            memread_EX_MEM, memwrite_EX_MEM, memtoreg_EX_MEM, regwrite_EX_MEM;
    logic [4:0]      rd_EX_MEM;
    logic            dmem_req, dmem_we, dmem_ready;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic            mem_stall;
    logic [XLEN-1:0] alu_result_MEM_WB, read_data_MEM_WB;
    logic            memtoreg_MEM_WB, regwrite_MEM_WB, bus_err_MEM_WB;
    logic [4:0]      rd_MEM_WB;

    mem_wb_stage #(
        .XLEN           (XLEN),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .alu_result_EX_MEM (alu_result_EX_MEM),
        .read_data2_EX_MEM (read_data2_EX_MEM),
        .memread_EX_MEM    (memread_EX_MEM),
        .memwrite_EX_MEM   (memwrite_EX_MEM),
        .memtoreg_EX_MEM   (memtoreg_EX_MEM),
        .regwrite_EX_MEM   (regwrite_EX_MEM),
        .rd_EX_MEM         (rd_EX_MEM),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_ready        (dmem_ready),
        .dmem_rdata        (dmem_rdata),
        .mem_stall         (mem_stall),
        .alu_result_MEM_WB (alu_result_MEM_WB),
        .read_data_MEM_WB  (read_data_MEM_WB),
        .memtoreg_MEM_WB   (memtoreg_MEM_WB),
        .regwrite_MEM_WB   (regwrite_MEM_WB),
        .rd_MEM_WB         (rd_MEM_WB),
        .bus_err_MEM_WB    (bus_err_MEM_WB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic        mtr;
        logic [31:0] rdata;
        logic        berr;
        logic        full;  // 0: only rw/berr/rdata are defined
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
    } req_t;

    wb_t         wb_q[$];
    req_t        req_exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          ready_delay = 0;  // ready in this WAIT cycle (1-based); 0 = never
    logic [31:0] ready_data = '0;
    bit          issuing = 0;

    function automatic wb_t mk_wb(input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                                  input logic mtr, input logic [31:0] rdata, input logic berr,
                                  input logic full);
        wb_t e;
        e.rw = rw; e.rd = rd; e.alu = alu; e.mtr = mtr;
        e.rdata = rdata; e.berr = berr; e.full = full;
        return e;
    endfunction

    function automatic req_t mk_req(input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input int len);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.len = len;
        return r;
    endfunction

    // Memory model: counts WAIT cycles of the current request and raises ready.
    initial begin
        int cnt;
        cnt = 0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (dmem_req === 1'b1) cnt++;
            else cnt = 0;
            dmem_ready = (ready_delay != 0) && (cnt == ready_delay);
            dmem_rdata = dmem_ready ? ready_data : 32'h0;
        end
    end

    // MEM/WB monitor: pops one expectation for every edge at which an issued op advanced.
    initial begin
        bit  pending;
        wb_t e;
        pending = 0;
        forever begin
            @(negedge clk);
            #2;
            if (pending) begin
                checks++;
                if (wb_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: MEM/WB update with no queued expectation");
                end else begin
                    e = wb_q.pop_front();
                    if (regwrite_MEM_WB !== e.rw || bus_err_MEM_WB !== e.berr ||
                        read_data_MEM_WB !== e.rdata ||
                        (e.full && (rd_MEM_WB !== e.rd || alu_result_MEM_WB !== e.alu ||
                                    memtoreg_MEM_WB !== e.mtr))) begin
                        errors++;
                        $display("FAIL wb_result: got rw=%0b rd=%0d alu=%h mtr=%0b rdata=%h berr=%0b want rw=%0b rd=%0d alu=%h mtr=%0b rdata=%h berr=%0b",
                                 regwrite_MEM_WB, rd_MEM_WB, alu_result_MEM_WB, memtoreg_MEM_WB,
                                 read_data_MEM_WB, bus_err_MEM_WB, e.rw, e.rd, e.alu, e.mtr,
                                 e.rdata, e.berr);
                    end
                end
            end
            pending = (reset === 1'b1) && (mem_stall === 1'b0) && issuing;
        end
    end

    // Request monitor: checks fields at request start, stability while held and length.
    initial begin
        bit   prev;
        int   len;
        req_t cur;
        prev = 0;
        len = 0;
        cur = mk_req(1'b0, 32'h0, 32'h0, -1);
        forever begin
            @(negedge clk);
            #2;
            if (dmem_req === 1'b1 && !prev) begin
                checks++;
                len = 1;
                if (req_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL req_unexpected: got addr=%h we=%0b want no request",
                             dmem_addr, dmem_we);
                end else begin
                    cur = req_exp_q.pop_front();
                    if (dmem_we !== cur.we || dmem_addr !== cur.addr ||
                        (cur.we && dmem_wdata !== cur.wdata)) begin
                        errors++;
                        $display("FAIL req_fields: got we=%0b addr=%h wdata=%h want we=%0b addr=%h wdata=%h",
                                 dmem_we, dmem_addr, dmem_wdata, cur.we, cur.addr, cur.wdata);
                    end
                end
            end else if (dmem_req === 1'b1 && prev) begin
                len++;
                checks++;
                if (dmem_we !== cur.we || dmem_addr !== cur.addr ||
                    (cur.we && dmem_wdata !== cur.wdata)) begin
                    errors++;
                    $display("FAIL req_stable: got we=%0b addr=%h wdata=%h want we=%0b addr=%h wdata=%h",
                             dmem_we, dmem_addr, dmem_wdata, cur.we, cur.addr, cur.wdata);
                end
            end else if (dmem_req !== 1'b1 && prev) begin
                checks++;
                if (len != cur.len) begin
                    errors++;
                    $display("FAIL req_length: got %0d cycles want %0d", len, cur.len);
                end
            end
            prev = (dmem_req === 1'b1);
        end
    end

    task automatic drive(input logic mr, input logic mw, input logic mtr, input logic rw,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rd2);
        memread_EX_MEM    = mr;
        memwrite_EX_MEM   = mw;
        memtoreg_EX_MEM   = mtr;
        regwrite_EX_MEM   = rw;
        rd_EX_MEM         = rd;
        alu_result_EX_MEM = alu;
        read_data2_EX_MEM = rd2;
    endtask

    // Presents one op and holds it until the stage advances; checks cycles occupied.
    task automatic issue(input string name, input logic mr, input logic mw, input logic mtr,
                         input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] rd2, input wb_t e, input int exp_occ);
        int occ;
        bit st;
        @(negedge clk);
        drive(mr, mw, mtr, rw, rd, alu, rd2);
        wb_q.push_back(e);
        issuing = 1;
        occ = 0;
        forever begin
            #1;
            st = mem_stall;
            occ++;
            @(posedge clk);
            if (!st) break;
            if (occ > 40) begin
                errors++;
                checks++;
                $display("FAIL %s_hang: got stall after %0d cycles want release", name, occ);
                break;
            end
            @(negedge clk);
        end
        issuing = 0;
        checks++;
        if (occ != exp_occ) begin
            errors++;
            $display("FAIL %s_occupancy: got %0d cycles want %0d", name, occ, exp_occ);
        end
    endtask

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check1("reset_outputs", {31'b0, dmem_req | dmem_we | regwrite_MEM_WB | memtoreg_MEM_WB |
               bus_err_MEM_WB | mem_stall | (|rd_MEM_WB) | (|dmem_addr) | (|dmem_wdata) |
               (|alu_result_MEM_WB) | (|read_data_MEM_WB)}, 32'h0);
        reset = 1'b1;

        // ALU op: one-cycle pass-through, never stalls.
        issue("alu", 0, 0, 0, 1, 5'd5, 32'h10, 32'h0,
              mk_wb(1, 5'd5, 32'h10, 0, 32'h0, 0, 1), 1);

        // Load 0x100, ready in third WAIT cycle.
        ready_delay = 3;
        ready_data  = 32'hDEADBEEF;
        req_exp_q.push_back(mk_req(0, 32'h100, 32'h0, 3));
        issue("load", 1, 0, 1, 1, 5'd7, 32'h100, 32'hAAAA5555,
              mk_wb(1, 5'd7, 32'h100, 1, 32'hDEADBEEF, 0, 1), 4);

        // Store 0x200, ready in first WAIT cycle; load data register holds.
        ready_delay = 1;
        ready_data  = 32'h0BADF00D;
        req_exp_q.push_back(mk_req(1, 32'h200, 32'h12345678, 1));
        issue("store", 0, 1, 0, 0, 5'd0, 32'h200, 32'h12345678,
              mk_wb(0, 5'd0, 32'h200, 0, 32'hDEADBEEF, 0, 1), 2);

        issue("alu2", 0, 0, 0, 1, 5'd9, 32'h55, 32'h0,
              mk_wb(1, 5'd9, 32'h55, 0, 32'hDEADBEEF, 0, 1), 1);

        // Both read and write set: read wins, we=0.
        ready_delay = 2;
        ready_data  = 32'hCAFEF00D;
        req_exp_q.push_back(mk_req(0, 32'h300, 32'h0, 2));
        issue("rw_both", 1, 1, 1, 1, 5'd11, 32'h300, 32'h77777777,
              mk_wb(1, 5'd11, 32'h300, 1, 32'hCAFEF00D, 0, 1), 3);

        // Timeout: ready never comes, bus error after TO WAIT cycles.
        ready_delay = 0;
        req_exp_q.push_back(mk_req(0, 32'h400, 32'h0, TO));
        issue("timeout", 1, 0, 1, 1, 5'd3, 32'h400, 32'h0,
              mk_wb(0, 5'd0, 32'h0, 0, 32'hCAFEF00D, 1, 0), TO + 1);

        // Following op sees bus error cleared.
        issue("after_to", 0, 0, 0, 1, 5'd12, 32'h66, 32'h0,
              mk_wb(1, 5'd12, 32'h66, 0, 32'hCAFEF00D, 0, 1), 1);

`ifdef MEM_MISALIGN_TRAP_EN
        issue("misalign", 1, 0, 1, 1, 5'd4, 32'h102, 32'h0,
              mk_wb(0, 5'd0, 32'h0, 0, 32'hCAFEF00D, 1, 0), 1);
`else
        ready_delay = 1;
        ready_data  = 32'h13572468;
        req_exp_q.push_back(mk_req(0, 32'h102, 32'h0, 1));
        issue("misalign", 1, 0, 1, 1, 5'd4, 32'h102, 32'h0,
              mk_wb(1, 5'd4, 32'h102, 1, 32'h13572468, 0, 1), 2);
`endif

        // Reset asserted in the middle of a WAIT.
        @(negedge clk);
        ready_delay = 0;
        drive(1, 0, 1, 1, 5'd8, 32'h500, 32'h0);
        req_exp_q.push_back(mk_req(0, 32'h500, 32'h0, 2));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check1("reset_in_wait_regs", {31'b0, dmem_req | dmem_we | regwrite_MEM_WB |
               memtoreg_MEM_WB | bus_err_MEM_WB | (|rd_MEM_WB) | (|dmem_addr) | (|dmem_wdata) |
               (|alu_result_MEM_WB) | (|read_data_MEM_WB)}, 32'h0);
        check1("reset_idle_stall_op", {31'b0, mem_stall}, 32'h1);
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        #1;
        check1("reset_idle_stall_noop", {31'b0, mem_stall}, 32'h0);
        reset = 1'b1;

        issue("post_reset", 0, 0, 0, 1, 5'd1, 32'h99, 32'h0,
              mk_wb(1, 5'd1, 32'h99, 0, 32'h0, 0, 1), 1);

        @(negedge clk);
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        repeat (4) @(negedge clk);
        check1("wb_queue_drained", wb_q.size(), 32'h0);
        check1("req_queue_drained", req_exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
